// File: rtl/pci_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pci_pkg : shared commands, active-low levels and FSM states          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pci_pkg;

  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  localparam logic ASSERT   = 1'b0;
  localparam logic DEASSERT = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    RD_TURN = 3'd2,
    RD_DATA = 3'd3,
    DISC    = 3'd4,
    IGNORE  = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pci_target_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pci_target_mem : DEPTH x 32 byte-writable store, async read port     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pci_target_mem #(
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem_q [DEPTH];

  // Contents are deliberately left out of reset so data survives an RST pulse.
  always_ff @(posedge CLK) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule
`default_nettype wire

// File: rtl/pci_target_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pci_target_responder : PCI memory target with local word store       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pci_target_responder
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          DEPTH     = 16,
  parameter int          CNT_W     = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FRAME_n,
  input  logic             IRDY_n,
  input  logic [3:0]       CBE_n,
  input  logic [31:0]      AD_in,
  output logic [31:0]      AD_out,
  output logic             AD_oe,
  output logic             DEVSEL_n,
  output logic             TRDY_n,
  output logic             STOP_n,
  output logic [CNT_W-1:0] xfer_count,
  output logic             done
);

  localparam int              IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               frame_prev_q;
  logic               devsel_n_q, devsel_n_d;
  logic               trdy_n_q, trdy_n_d;
  logic               stop_n_q, stop_n_d;
  logic               ad_oe_q, ad_oe_d;
  logic [31:0]        ad_out_q, ad_out_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   xfer_count_q, xfer_count_d;

  logic               xfer, hit, mem_we;
  logic [IDX_W-1:0]   addr_idx, idx_inc, rd_idx;
  logic [31:0]        rd_data;
  logic               unused_ad_lsbs;

  assign xfer     = (IRDY_n == ASSERT) && (trdy_n_q == ASSERT);
  assign addr_idx = AD_in[IDX_W+1:2];
  assign hit      = (AD_in[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
  assign idx_inc  = idx_q + IDX_W'(1);
  assign mem_we   = (state_q == WR_DATA) && xfer;
  // RD_DATA prefetches the next word so it lands on AD at the xfer edge.
  assign rd_idx   = (state_q == RD_DATA) ? idx_inc : idx_q;
  assign unused_ad_lsbs = ^AD_in[1:0];

  pci_target_mem #(.DEPTH(DEPTH)) u_mem (
    .CLK     (CLK),
    .we      (mem_we),
    .be      (~CBE_n),
    .wr_idx  (idx_q),
    .wr_data (AD_in),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    devsel_n_d   = devsel_n_q;
    trdy_n_d     = trdy_n_q;
    stop_n_d     = stop_n_q;
    ad_oe_d      = ad_oe_q;
    ad_out_d     = ad_out_q;
    done_d       = 1'b0;
    xfer_count_d = xfer_count_q;
    unique case (state_q)
      IDLE: begin
        if ((FRAME_n == ASSERT) && frame_prev_q) begin
          idx_d        = addr_idx;
          xfer_count_d = '0;
          if (hit && (CBE_n == CMD_MEM_WRITE)) begin
            state_d    = WR_DATA;
            devsel_n_d = ASSERT;
            trdy_n_d   = ASSERT;
            stop_n_d   = (addr_idx == LAST_IDX) ? ASSERT : DEASSERT;
          end else if (hit && (CBE_n == CMD_MEM_READ)) begin
            state_d    = RD_TURN;
            devsel_n_d = ASSERT;
          end else begin
            state_d    = IGNORE;
          end
        end
      end
      RD_TURN: begin
        state_d  = RD_DATA;
        ad_out_d = rd_data;
        ad_oe_d  = 1'b1;
        trdy_n_d = ASSERT;
        stop_n_d = (idx_q == LAST_IDX) ? ASSERT : DEASSERT;
      end
      WR_DATA, RD_DATA: begin
        if (xfer) begin
          xfer_count_d = xfer_count_q + CNT_W'(1);
          if (FRAME_n == DEASSERT) begin
            state_d    = IDLE;
            devsel_n_d = DEASSERT;
            trdy_n_d   = DEASSERT;
            stop_n_d   = DEASSERT;
            ad_oe_d    = 1'b0;
            done_d     = 1'b1;
          end else if (idx_q == LAST_IDX) begin
            // Last word taken with FRAME still low: hold STOP until it rises.
            state_d  = DISC;
            trdy_n_d = DEASSERT;
            stop_n_d = ASSERT;
            ad_oe_d  = 1'b0;
          end else begin
            idx_d    = idx_inc;
            stop_n_d = (idx_inc == LAST_IDX) ? ASSERT : DEASSERT;
            if (state_q == RD_DATA) ad_out_d = rd_data;
          end
        end
      end
      DISC: begin
        if (FRAME_n == DEASSERT) begin
          state_d    = IDLE;
          devsel_n_d = DEASSERT;
          trdy_n_d   = DEASSERT;
          stop_n_d   = DEASSERT;
          ad_oe_d    = 1'b0;
          done_d     = 1'b1;
        end
      end
      IGNORE: begin
        if ((FRAME_n == DEASSERT) && (IRDY_n == DEASSERT)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      frame_prev_q <= 1'b0;
      devsel_n_q   <= DEASSERT;
      trdy_n_q     <= DEASSERT;
      stop_n_q     <= DEASSERT;
      ad_oe_q      <= 1'b0;
      ad_out_q     <= '0;
      done_q       <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_prev_q <= FRAME_n;
      devsel_n_q   <= devsel_n_d;
      trdy_n_q     <= trdy_n_d;
      stop_n_q     <= stop_n_d;
      ad_oe_q      <= ad_oe_d;
      ad_out_q     <= ad_out_d;
      done_q       <= done_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign AD_out     = ad_out_q;
  assign AD_oe      = ad_oe_q;
  assign DEVSEL_n   = devsel_n_q;
  assign TRDY_n     = trdy_n_q;
  assign STOP_n     = stop_n_q;
  assign xfer_count = xfer_count_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pci_target_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pci_target_responder : randomized bench with transaction model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pci_target_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        FRAME_n = 1'b1;
  logic        IRDY_n = 1'b1;
  logic [3:0]  CBE_n = 4'hF;
  logic [31:0] AD_in = 32'h0;
  logic [31:0] AD_out;
  logic        AD_oe, DEVSEL_n, TRDY_n, STOP_n, done;
  logic [4:0]  xfer_count;

  logic [31:0] ref_mem [16];
  int checks = 0;
  int failures = 0;

  pci_target_responder #(.BASE_ADDR(32'h0000_1000), .DEPTH(16), .CNT_W(5)) dut (
    .CLK(CLK), .RST(RST), .FRAME_n(FRAME_n), .IRDY_n(IRDY_n), .CBE_n(CBE_n),
    .AD_in(AD_in), .AD_out(AD_out), .AD_oe(AD_oe), .DEVSEL_n(DEVSEL_n),
    .TRDY_n(TRDY_n), .STOP_n(STOP_n), .xfer_count(xfer_count), .done(done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Packs {DEVSEL_n,TRDY_n,STOP_n,AD_oe,done}, xfer_count and optionally AD_out.
  function automatic logic [41:0] obs(input logic with_ad);
    return {DEVSEL_n, TRDY_n, STOP_n, AD_oe, done, xfer_count, with_ad ? AD_out : 32'h0};
  endfunction

  function automatic logic [41:0] mk(input logic [4:0] ctl, input int cnt, input logic [31:0] ad);
    return {ctl, 5'(cnt), ad};
  endfunction

  task automatic idle_bus();
    FRAME_n = 1'b1; IRDY_n = 1'b1; CBE_n = 4'hF; AD_in = $urandom;
  endtask

  task automatic run_write(input logic [31:0] addr, input int n, input int wait_ph,
                           input logic [31:0] d0, input logic [3:0] be0, input bit rnd_be,
                           input string tag);
    int idx = int'(addr[5:2]);
    int cnt = 0;
    logic [31:0] d;
    logic [3:0]  be;
    logic [41:0] want;
    FRAME_n = 1'b0; IRDY_n = 1'b1; CBE_n = 4'b0111; AD_in = addr;
    cyc();
    want = mk({2'b00, idx != 15, 2'b00}, 0, 32'h0);
    checks++; if (obs(1'b0) !== want) begin failures++; $display("FAIL %s/claim got=%h want=%h", tag, obs(1'b0), want); end
    for (int k = 0; k < n; k++) begin
      if (k == wait_ph) begin
        IRDY_n = 1'b1; FRAME_n = 1'b0; AD_in = $urandom; CBE_n = 4'(int'($urandom_range(0, 15)));
        cyc();
        checks++; if (obs(1'b0) !== want) begin failures++; $display("FAIL %s/wait got=%h want=%h", tag, obs(1'b0), want); end
      end
      d  = (k == 0) ? d0 : $urandom;
      be = (k == 0) ? be0 : (rnd_be ? 4'(int'($urandom_range(0, 15))) : 4'h0);
      IRDY_n = 1'b0; FRAME_n = (k == n - 1); AD_in = d; CBE_n = be;
      cyc();
      for (int b = 0; b < 4; b++) if (!be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      cnt++;
      if (k == n - 1) begin
        want = mk(5'b11101, cnt, 32'h0);
        checks++; if (obs(1'b0) !== want) begin failures++; $display("FAIL %s/end got=%h want=%h", tag, obs(1'b0), want); end
        break;
      end
      if (idx == 15) begin
        want = mk(5'b01000, cnt, 32'h0);
        checks++; if (obs(1'b0) !== want) begin failures++; $display("FAIL %s/disc got=%h want=%h", tag, obs(1'b0), want); end
        IRDY_n = 1'b1;
        cyc();
        checks++; if (obs(1'b0) !== want) begin failures++; $display("FAIL %s/disc_hold got=%h want=%h", tag, obs(1'b0), want); end
        FRAME_n = 1'b1;
        cyc();
        want = mk(5'b11101, cnt, 32'h0);
        checks++; if (obs(1'b0) !== want) begin failures++; $display("FAIL %s/disc_end got=%h want=%h", tag, obs(1'b0), want); end
        break;
      end
      idx++;
      want = mk({2'b00, idx != 15, 2'b00}, cnt, 32'h0);
      checks++; if (obs(1'b0) !== want) begin failures++; $display("FAIL %s/phase%0d got=%h want=%h", tag, k, obs(1'b0), want); end
    end
    idle_bus();
    cyc();
    want = mk(5'b11100, cnt, 32'h0);
    checks++; if (obs(1'b0) !== want) begin failures++; $display("FAIL %s/idle got=%h want=%h", tag, obs(1'b0), want); end
  endtask

  task automatic run_read(input logic [31:0] addr, input int n, input int wait_ph, input string tag);
    int idx = int'(addr[5:2]);
    int cnt = 0;
    logic [41:0] want;
    FRAME_n = 1'b0; IRDY_n = 1'b1; CBE_n = 4'b0110; AD_in = addr;
    cyc();
    want = mk(5'b01100, 0, 32'h0);
    checks++; if (obs(1'b0) !== want) begin failures++; $display("FAIL %s/turn got=%h want=%h", tag, obs(1'b0), want); end
    AD_in = $urandom; CBE_n = 4'h0;
    cyc();
    want = mk({2'b00, idx != 15, 2'b10}, 0, ref_mem[idx]);
    checks++; if (obs(1'b1) !== want) begin failures++; $display("FAIL %s/first got=%h want=%h", tag, obs(1'b1), want); end
    for (int k = 0; k < n; k++) begin
      if (k == wait_ph) begin
        IRDY_n = 1'b1; FRAME_n = 1'b0;
        cyc();
        checks++; if (obs(1'b1) !== want) begin failures++; $display("FAIL %s/wait got=%h want=%h", tag, obs(1'b1), want); end
      end
      IRDY_n = 1'b0; FRAME_n = (k == n - 1);
      cyc();
      cnt++;
      if (k == n - 1) begin
        want = mk(5'b11101, cnt, 32'h0);
        checks++; if (obs(1'b0) !== want) begin failures++; $display("FAIL %s/end got=%h want=%h", tag, obs(1'b0), want); end
        break;
      end
      if (idx == 15) begin
        want = mk(5'b01000, cnt, 32'h0);
        checks++; if (obs(1'b0) !== want) begin failures++; $display("FAIL %s/disc got=%h want=%h", tag, obs(1'b0), want); end
        FRAME_n = 1'b1;
        cyc();
        want = mk(5'b11101, cnt, 32'h0);
        checks++; if (obs(1'b0) !== want) begin failures++; $display("FAIL %s/disc_end got=%h want=%h", tag, obs(1'b0), want); end
        break;
      end
      idx++;
      want = mk({2'b00, idx != 15, 2'b10}, cnt, ref_mem[idx]);
      checks++; if (obs(1'b1) !== want) begin failures++; $display("FAIL %s/phase%0d got=%h want=%h", tag, k, obs(1'b1), want); end
    end
    idle_bus();
    cyc();
    want = mk(5'b11100, cnt, 32'h0);
    checks++; if (obs(1'b0) !== want) begin failures++; $display("FAIL %s/idle got=%h want=%h", tag, obs(1'b0), want); end
  endtask

  task automatic test_reset();
    logic [41:0] want = mk(5'b11100, 0, 32'h0);
    RST = 1'b0;
    idle_bus();
    cyc();
    cyc();
    checks++; if (obs(1'b1) !== want) begin failures++; $display("FAIL reset got=%h want=%h", obs(1'b1), want); end
    RST = 1'b1;
    cyc();
  endtask

  task automatic test_preload();
    run_write(32'h1000, 16, -1, $urandom, 4'h0, 1'b0, "preload");
    run_read(32'h1000, 16, 5, "preload_rd");
  endtask

  task automatic test_single_write();
    run_write(32'h1008, 1, -1, 32'hDEAD_BEEF, 4'h0, 1'b0, "single_wr");
    run_read(32'h1008, 1, -1, "single_rd");
  endtask

  task automatic test_read_burst();
    run_write(32'h1008, 3, -1, $urandom, 4'h0, 1'b0, "abc_wr");
    run_read(32'h1008, 3, 1, "burst_rd");
  endtask

  task automatic test_byte_enable();
    run_write(32'h1000, 1, -1, 32'h1122_3344, 4'h0, 1'b0, "be_init");
    run_write(32'h1000, 1, -1, 32'hAABB_CCDD, 4'b1010, 1'b0, "be_wr");
    run_read(32'h1000, 1, -1, "be_rd");
  endtask

  task automatic test_ignore();
    logic [31:0] addrs [2] = '{32'h2000, 32'h1000};
    logic [3:0]  cmds  [2] = '{4'b0111, 4'b0010};
    logic [41:0] want = mk(5'b11100, 0, 32'h0);
    for (int t = 0; t < 2; t++) begin
      FRAME_n = 1'b0; IRDY_n = 1'b1; CBE_n = cmds[t]; AD_in = addrs[t];
      cyc();
      checks++; if (obs(1'b0) !== want) begin failures++; $display("FAIL ignore%0d/addr got=%h want=%h", t, obs(1'b0), want); end
      FRAME_n = 1'b1; IRDY_n = 1'b0; CBE_n = 4'h0; AD_in = $urandom;
      cyc();
      checks++; if (obs(1'b0) !== want) begin failures++; $display("FAIL ignore%0d/data got=%h want=%h", t, obs(1'b0), want); end
      idle_bus();
      cyc();
      checks++; if (obs(1'b0) !== want) begin failures++; $display("FAIL ignore%0d/idle got=%h want=%h", t, obs(1'b0), want); end
    end
    run_read(32'h1000, 1, -1, "ignore_rd");
  endtask

  task automatic test_disconnect();
    run_write(32'h103C, 3, -1, 32'hCAFE_F00D, 4'h0, 1'b0, "disc_wr");
    run_read(32'h1038, 4, 0, "disc_rd");
  endtask

  task automatic test_reset_mid();
    logic [41:0] want;
    FRAME_n = 1'b0; IRDY_n = 1'b1; CBE_n = 4'b0110; AD_in = 32'h1010;
    cyc();
    AD_in = $urandom; CBE_n = 4'h0;
    cyc();
    IRDY_n = 1'b0;
    cyc();
    want = mk(5'b00110, 1, ref_mem[5]);
    checks++; if (obs(1'b1) !== want) begin failures++; $display("FAIL rst_mid/pre got=%h want=%h", obs(1'b1), want); end
    RST = 1'b0;
    cyc();
    want = mk(5'b11100, 0, 32'h0);
    checks++; if (obs(1'b1) !== want) begin failures++; $display("FAIL rst_mid/reset got=%h want=%h", obs(1'b1), want); end
    RST = 1'b1; AD_in = 32'h1010; CBE_n = 4'b0110;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if (obs(1'b0) !== want) begin failures++; $display("FAIL rst_mid/noclaim%0d got=%h want=%h", i, obs(1'b0), want); end
    end
    idle_bus();
    cyc();
    run_read(32'h1010, 3, -1, "rst_mid_rd");
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      int idx = int'($urandom_range(0, 15));
      int n   = int'($urandom_range(1, 4));
      int w   = int'($urandom_range(0, 5)) - 1;
      logic [31:0] a = 32'h1000 + 32'(idx * 4);
      if ($urandom_range(0, 1) == 0)
        run_write(a, n, w, $urandom, 4'(int'($urandom_range(0, 15))), 1'b1, "rnd_wr");
      else
        run_read(a, n, w, "rnd_rd");
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_single_write();
    test_read_burst();
    test_byte_enable();
    test_ignore();
    test_disconnect();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
